// File: rtl/dma_csr_queue_pkg.sv
// Shared register map, status/event bit positions and descriptor layout for dma_csr_queue.
// No logic; constants and types only.
// Backpressure: n/a.
package dma_csr_queue_pkg;

    localparam logic [11:0] CH_STRIDE      = 12'h040;
    localparam logic [11:0] REG_IRQ_STATUS = 12'hF00;

    localparam logic [5:0] REG_CTRL     = 6'h00;
    localparam logic [5:0] REG_ADDR     = 6'h08;
    localparam logic [5:0] REG_LEN      = 6'h10;
    localparam logic [5:0] REG_PUSH     = 6'h18;
    localparam logic [5:0] REG_STATUS   = 6'h20;
    localparam logic [5:0] REG_EVENTS   = 6'h28;
    localparam logic [5:0] REG_DONE_CNT = 6'h30;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;
    localparam int CTRL_FLUSH_BIT  = 2;

    localparam int ST_BUSY_BIT  = 0;
    localparam int ST_EMPTY_BIT = 1;
    localparam int ST_FULL_BIT  = 2;
    localparam int ST_CNT_LSB   = 8;

    localparam int EV_DONE_BIT = 0;
    localparam int EV_OVF_BIT  = 1;
    localparam int EV_ERR_BIT  = 2;
    localparam int EV_W        = 3;

    // Widest packet count any instance may use; narrower LEN_W is zero-extended.
    localparam int DESC_LEN_MAX = 64;

    typedef struct packed {
        logic [63:0]             addr;
        logic [DESC_LEN_MAX-1:0] len;
    } desc_t;

    typedef enum logic [1:0] {
        CH_IDLE  = 2'd0,
        CH_ISSUE = 2'd1,
        CH_RUN   = 2'd2
    } ch_state_e;

endpackage

// File: rtl/desc_fifo.sv
// Synchronous descriptor FIFO with occupancy count and synchronous clear.
// Latency: a written entry is visible at rd_dat from the following cycle.
// Backpressure: writes while full are dropped unless a read frees a slot in the same cycle.
module desc_fifo #(
    parameter int  W     = 96,
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          clr,
    input  logic          wr_vld,
    input  logic [W-1:0]  wr_dat,
    input  logic          rd_rdy,
    output logic [W-1:0]  rd_dat,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_wr;
    logic          do_rd;

    assign empty  = (count == '0);
    assign full   = (count == CW'(DEPTH));
    assign do_rd  = rd_rdy && !empty && !clr;
    assign do_wr  = wr_vld && (!full || do_rd) && !clr;
    assign rd_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_wr) - CW'(do_rd);
        end
    end

endmodule

// File: rtl/dma_csr_queue.sv
// MMIO register front-end queuing DMA descriptors per channel and issuing them to an engine.
// Latency: rdata is combinational; a queued descriptor reaches ch_start one cycle after it is eligible.
// Backpressure: ch_start holds until ch_busy; PUSH into a full queue drops and flags overflow.
module dma_csr_queue
    import dma_csr_queue_pkg::*;
#(
    parameter int          N_CH       = 2,
    parameter int          DESC_DEPTH = 4,
    parameter logic [63:0] MMIO_BASE  = 64'h4000_0000,
    parameter int          LEN_W      = 32
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [63:0]                addr,
    input  logic [63:0]                wdata,
    input  logic                       we,
    output logic [63:0]                rdata,
    output logic [N_CH-1:0]            ch_start,
    output logic [N_CH-1:0][63:0]      ch_addr,
    output logic [N_CH-1:0][LEN_W-1:0] ch_len,
    input  logic [N_CH-1:0]            ch_busy,
    input  logic [N_CH-1:0]            ch_done,
    input  logic [N_CH-1:0]            ch_err,
    output logic                       irq
);
    localparam int CW = $clog2(DESC_DEPTH) + 1;
    localparam int FW = 64 + LEN_W;

    logic            hit;
    logic [11:0]     off;
    logic [5:0]      ch_sel;
    logic [5:0]      reg_sel;
    logic [N_CH-1:0] irq_src;
    logic [63:0]     ch_rdata [N_CH];

    assign hit     = ((addr & ~64'hFFF) == MMIO_BASE);
    assign off     = addr[11:0];
    assign ch_sel  = 6'(off / CH_STRIDE);
    assign reg_sel = 6'(off % CH_STRIDE);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic              wr_sel;
        logic              wr_ctrl;
        logic              push_req;
        logic              en_q;
        logic              irq_en_q;
        logic              flush_q;
        logic [63:0]       stg_addr_q;
        logic [LEN_W-1:0]  stg_len_q;
        logic [EV_W-1:0]   ev_q;
        logic [EV_W-1:0]   ev_set;
        logic [EV_W-1:0]   ev_clr;
        logic [31:0]       done_cnt_q;
        logic [63:0]       addr_q;
        logic [LEN_W-1:0]  len_q;
        ch_state_e         state_q;
        ch_state_e         state_d;
        logic              pop;
        logic              issue_ld;
        logic              zero_done;
        logic              run_done;
        logic              run_err;
        logic              ovf;
        logic [FW-1:0]     fifo_rd;
        logic [CW-1:0]     fifo_cnt;
        logic              fifo_empty;
        logic              fifo_full;
        desc_t             head;
        logic [63:0]       status;

        assign wr_sel   = hit && we && (ch_sel == 6'(g));
        assign wr_ctrl  = wr_sel && (reg_sel == REG_CTRL);
        assign push_req = wr_sel && (reg_sel == REG_PUSH);
        assign ev_clr   = (wr_sel && (reg_sel == REG_EVENTS)) ? wdata[EV_W-1:0] : '0;

        desc_fifo #(
            .W     (FW),
            .DEPTH (DESC_DEPTH)
        ) u_fifo (
            .clk    (clk),
            .rstn   (rstn),
            .clr    (flush_q),
            .wr_vld (push_req),
            .wr_dat ({stg_addr_q, stg_len_q}),
            .rd_rdy (pop),
            .rd_dat (fifo_rd),
            .count  (fifo_cnt),
            .empty  (fifo_empty),
            .full   (fifo_full)
        );

        assign head = '{addr: fifo_rd[LEN_W +: 64], len: DESC_LEN_MAX'(fifo_rd[LEN_W-1:0])};

        always_comb begin
            state_d   = state_q;
            pop       = 1'b0;
            issue_ld  = 1'b0;
            zero_done = 1'b0;
            run_done  = 1'b0;
            run_err   = 1'b0;
            case (state_q)
                CH_IDLE: begin
                    if (en_q && !fifo_empty && !flush_q) begin
                        pop = 1'b1;
                        if (head.len != '0) begin
                            issue_ld = 1'b1;
                            state_d  = CH_ISSUE;
                        end else begin
                            zero_done = 1'b1;
                        end
                    end
                end
                CH_ISSUE: begin
                    if (ch_busy[g]) state_d = CH_RUN;
                end
                CH_RUN: begin
                    if (ch_done[g]) begin
                        run_done = 1'b1;
                        state_d  = CH_IDLE;
                    end else if (ch_err[g]) begin
                        run_err = 1'b1;
                        state_d = CH_IDLE;
                    end
                end
                default: state_d = CH_IDLE;
            endcase
        end

        // A push into a full queue survives only if the head leaves in the same cycle.
        assign ovf = push_req && fifo_full && !pop && !flush_q;

        always_comb begin
            ev_set              = '0;
            ev_set[EV_DONE_BIT] = run_done || zero_done;
            ev_set[EV_OVF_BIT]  = ovf;
            ev_set[EV_ERR_BIT]  = run_err;
        end

        always_ff @(posedge clk) begin
            if (!rstn) begin
                state_q    <= CH_IDLE;
                en_q       <= 1'b0;
                irq_en_q   <= 1'b0;
                flush_q    <= 1'b0;
                stg_addr_q <= '0;
                stg_len_q  <= '0;
                ev_q       <= '0;
                done_cnt_q <= '0;
                addr_q     <= '0;
                len_q      <= '0;
            end else begin
                state_q <= state_d;
                flush_q <= wr_ctrl && wdata[CTRL_FLUSH_BIT];
                if (wr_ctrl) begin
                    en_q     <= wdata[CTRL_EN_BIT];
                    irq_en_q <= wdata[CTRL_IRQ_EN_BIT];
                end
                if (wr_sel && (reg_sel == REG_ADDR)) stg_addr_q <= wdata;
                if (wr_sel && (reg_sel == REG_LEN))  stg_len_q  <= wdata[LEN_W-1:0];
                ev_q <= (ev_q & ~ev_clr) | ev_set;
                if (ev_set[EV_DONE_BIT]) done_cnt_q <= done_cnt_q + 32'd1;
                if (issue_ld) begin
                    addr_q <= head.addr;
                    len_q  <= head.len[LEN_W-1:0];
                end
            end
        end

        assign ch_start[g] = (state_q == CH_ISSUE);
        assign ch_addr[g]  = addr_q;
        assign ch_len[g]   = len_q;
        assign irq_src[g]  = irq_en_q && (|ev_q);

        always_comb begin
            status                       = '0;
            status[ST_BUSY_BIT]          = (state_q != CH_IDLE);
            status[ST_EMPTY_BIT]         = fifo_empty;
            status[ST_FULL_BIT]          = fifo_full;
            status[ST_CNT_LSB +: 8]      = 8'(fifo_cnt);
            ch_rdata[g]                  = '0;
            case (reg_sel)
                REG_CTRL: begin
                    ch_rdata[g][CTRL_EN_BIT]     = en_q;
                    ch_rdata[g][CTRL_IRQ_EN_BIT] = irq_en_q;
                end
                REG_ADDR:     ch_rdata[g] = stg_addr_q;
                REG_LEN:      ch_rdata[g] = 64'(stg_len_q);
                REG_STATUS:   ch_rdata[g] = status;
                REG_EVENTS:   ch_rdata[g] = 64'(ev_q);
                REG_DONE_CNT: ch_rdata[g] = 64'(done_cnt_q);
                default:      ch_rdata[g] = '0;
            endcase
        end
    end

    always_comb begin
        rdata = '0;
        if (hit) begin
            if (off == REG_IRQ_STATUS) begin
                rdata = 64'(irq_src);
            end else begin
                for (int c = 0; c < N_CH; c++) begin
                    if (ch_sel == 6'(c)) rdata = ch_rdata[c];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) irq <= 1'b0;
        else       irq <= |irq_src;
    end

endmodule

// File: tb/tb_dma_csr_queue.sv
// Directed bench for dma_csr_queue with a small engine responder and hand-computed expectations.
module tb_dma_csr_queue;
    localparam logic [63:0] BASE = 64'h4000_0000;

    logic             clk = 1'b0;
    logic             rstn;
    logic [63:0]      addr;
    logic [63:0]      wdata;
    logic             we;
    logic [63:0]      rdata;
    logic [1:0]       ch_start;
    logic [1:0][63:0] ch_addr;
    logic [1:0][31:0] ch_len;
    logic [1:0]       ch_busy;
    logic [1:0]       ch_done;
    logic [1:0]       ch_err;
    logic             irq;

    int checks   = 0;
    int failures = 0;
    int busy_wait [2];
    int run_len   [2];
    bit eng_err   [2];
    int ph        [2];
    int ecnt      [2];
    int start_cnt [2];
    int start_cyc [2];
    int done_seen [2];
    logic [1:0] start_prev;
    int s_cnt;
    int s_cyc;
    int d_seen;

    dma_csr_queue #(
        .N_CH       (2),
        .DESC_DEPTH (4),
        .MMIO_BASE  (64'h4000_0000),
        .LEN_W      (32)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .addr     (addr),
        .wdata    (wdata),
        .we       (we),
        .rdata    (rdata),
        .ch_start (ch_start),
        .ch_addr  (ch_addr),
        .ch_len   (ch_len),
        .ch_busy  (ch_busy),
        .ch_done  (ch_done),
        .ch_err   (ch_err),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ra(input int c, input int r);
        return BASE + 64'(c * 64 + r);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // All bus tasks start and end on a falling edge.
    task automatic wr(input logic [63:0] a, input logic [63:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [63:0] a, input logic [63:0] exp);
        addr = a;
        we   = 1'b0;
        #1;
        check(tag, rdata, exp);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    // Engine model: raise busy busy_wait cycles after seeing start, finish run_len cycles later.
    initial begin
        ch_busy = '0;
        ch_done = '0;
        ch_err  = '0;
        ph      = '{0, 0};
        ecnt    = '{0, 0};
        forever begin
            @(negedge clk);
            for (int c = 0; c < 2; c++) begin
                ch_done[c] = 1'b0;
                ch_err[c]  = 1'b0;
                case (ph[c])
                    0: if (ch_start[c]) begin
                        ph[c]   = 1;
                        ecnt[c] = busy_wait[c] - 1;
                    end
                    1: if (ecnt[c] <= 0) begin
                        ch_busy[c] = 1'b1;
                        ph[c]      = 2;
                        ecnt[c]    = run_len[c] - 1;
                    end else begin
                        ecnt[c]--;
                    end
                    default: if (ecnt[c] <= 0) begin
                        ch_busy[c] = 1'b0;
                        ph[c]      = 0;
                        if (eng_err[c]) ch_err[c]  = 1'b1;
                        else            ch_done[c] = 1'b1;
                    end else begin
                        ecnt[c]--;
                    end
                endcase
            end
        end
    end

    initial begin
        start_prev = '0;
        start_cnt  = '{0, 0};
        start_cyc  = '{0, 0};
        done_seen  = '{0, 0};
        forever begin
            @(negedge clk);
            #1;
            for (int c = 0; c < 2; c++) begin
                if (ch_start[c]) begin
                    start_cyc[c]++;
                    if (!start_prev[c]) start_cnt[c]++;
                end
                if (ch_done[c]) done_seen[c]++;
            end
            start_prev = ch_start;
        end
    end

    initial begin
        rstn      = 1'b0;
        addr      = '0;
        wdata     = '0;
        we        = 1'b0;
        busy_wait = '{1, 1};
        run_len   = '{10, 10};
        eng_err   = '{0, 0};
        @(negedge clk);
        do_reset();

        // Reset state and address decode
        check("rst_start", 64'(ch_start), 64'h0);
        check("rst_irq", 64'(irq), 64'h0);
        rd_chk("rst_status0", ra(0, 'h20), 64'h2);
        rd_chk("rst_status1", ra(1, 'h20), 64'h2);
        rd_chk("rst_ctrl0", ra(0, 'h00), 64'h0);
        wr(64'h5000_0008, 64'hDEAD);
        rd_chk("oow_rd", 64'h5000_0008, 64'h0);
        rd_chk("oow_wr_ignored", ra(0, 'h08), 64'h0);
        wr(ra(0, 'h08), 64'h1234);
        rd_chk("undef_off", ra(0, 'h38), 64'h0);

        // Single descriptor: start held exactly until busy
        wr(ra(0, 'h08), 64'h1000);
        wr(ra(0, 'h10), 64'd3);
        wr(ra(0, 'h18), 64'h0);
        s_cyc = start_cyc[0];
        s_cnt = start_cnt[0];
        wr(ra(0, 'h00), 64'h1);
        @(negedge clk);
        check("t1_start", 64'(ch_start[0]), 64'h1);
        check("t1_addr", ch_addr[0], 64'h1000);
        check("t1_len", 64'(ch_len[0]), 64'd3);
        rd_chk("t1_status_issue", ra(0, 'h20), 64'h3);
        repeat (20) @(negedge clk);
        check("t1_start_cycles", 64'(start_cyc[0] - s_cyc), 64'd2);
        check("t1_start_count", 64'(start_cnt[0] - s_cnt), 64'd1);
        rd_chk("t1_done_cnt", ra(0, 'h30), 64'd1);
        rd_chk("t1_events", ra(0, 'h28), 64'h1);
        rd_chk("t1_status_idle", ra(0, 'h20), 64'h2);
        check("t1_irq", 64'(irq), 64'h0);

        // Overflow with enable off, then drain
        do_reset();
        run_len = '{2, 2};
        wr(ra(0, 'h08), 64'h2000);
        wr(ra(0, 'h10), 64'd5);
        for (int i = 0; i < 5; i++) wr(ra(0, 'h18), 64'h0);
        rd_chk("t2_status_full", ra(0, 'h20), 64'h404);
        rd_chk("t2_events_ovf", ra(0, 'h28), 64'h2);
        s_cnt = start_cnt[0];
        wr(ra(0, 'h00), 64'h1);
        repeat (60) @(negedge clk);
        check("t2_starts", 64'(start_cnt[0] - s_cnt), 64'd4);
        rd_chk("t2_done_cnt", ra(0, 'h30), 64'd4);
        rd_chk("t2_events", ra(0, 'h28), 64'h3);
        rd_chk("t2_status_empty", ra(0, 'h20), 64'h2);

        // Push and pop together while full
        wr(ra(0, 'h00), 64'h0);
        wr(ra(0, 'h28), 64'h7);
        for (int i = 0; i < 4; i++) wr(ra(0, 'h18), 64'h0);
        rd_chk("t2b_full", ra(0, 'h20), 64'h404);
        s_cnt = start_cnt[0];
        wr(ra(0, 'h00), 64'h1);
        wr(ra(0, 'h18), 64'h0);
        rd_chk("t2b_status", ra(0, 'h20), 64'h405);
        rd_chk("t2b_no_ovf", ra(0, 'h28), 64'h0);
        repeat (60) @(negedge clk);
        check("t2b_starts", 64'(start_cnt[0] - s_cnt), 64'd5);
        rd_chk("t2b_done_cnt", ra(0, 'h30), 64'd9);

        // Flush discards the queue and a push landing in the flush cycle
        do_reset();
        wr(ra(0, 'h10), 64'd7);
        wr(ra(0, 'h18), 64'h0);
        wr(ra(0, 'h18), 64'h0);
        rd_chk("fl_status_before", ra(0, 'h20), 64'h200);
        wr(ra(0, 'h00), 64'h4);
        wr(ra(0, 'h18), 64'h0);
        rd_chk("fl_status_after", ra(0, 'h20), 64'h2);
        rd_chk("fl_ctrl_reads0", ra(0, 'h00), 64'h0);
        rd_chk("fl_events", ra(0, 'h28), 64'h0);

        // Zero-length descriptor completes without a start; irq one cycle later
        do_reset();
        wr(ra(0, 'h00), 64'h3);
        s_cnt = start_cnt[0];
        wr(ra(0, 'h18), 64'h0);
        @(negedge clk);
        check("t3_irq_latency", 64'(irq), 64'h0);
        rd_chk("t3_done_cnt", ra(0, 'h30), 64'd1);
        @(negedge clk);
        check("t3_irq_set", 64'(irq), 64'h1);
        check("t3_no_start", 64'(start_cnt[0] - s_cnt), 64'd0);
        wr(ra(0, 'h28), 64'h1);
        check("t3_irq_hold", 64'(irq), 64'h1);
        @(negedge clk);
        check("t3_irq_clear", 64'(irq), 64'h0);
        rd_chk("t3_events_clr", ra(0, 'h28), 64'h0);

        // Two channels, ch1 ends in error
        do_reset();
        run_len = '{6, 4};
        eng_err = '{0, 1};
        wr(ra(0, 'h08), 64'h3000);
        wr(ra(0, 'h10), 64'd8);
        wr(ra(0, 'h18), 64'h0);
        wr(ra(1, 'h08), 64'h4000);
        wr(ra(1, 'h10), 64'd4);
        wr(ra(1, 'h18), 64'h0);
        wr(ra(1, 'h00), 64'h3);
        wr(ra(0, 'h00), 64'h1);
        repeat (30) @(negedge clk);
        rd_chk("t4_ev1", ra(1, 'h28), 64'h4);
        rd_chk("t4_done1", ra(1, 'h30), 64'd0);
        rd_chk("t4_ev0", ra(0, 'h28), 64'h1);
        rd_chk("t4_done0", ra(0, 'h30), 64'd1);
        rd_chk("t4_irq_status", BASE + 64'hF00, 64'h2);
        check("t4_irq", 64'(irq), 64'h1);
        check("t4_addr1", ch_addr[1], 64'h4000);
        check("t4_len1", 64'(ch_len[1]), 64'd4);

        // Reset while running with two queued
        do_reset();
        eng_err = '{0, 0};
        run_len = '{30, 4};
        wr(ra(0, 'h08), 64'h5000);
        wr(ra(0, 'h10), 64'd9);
        for (int i = 0; i < 3; i++) wr(ra(0, 'h18), 64'h0);
        wr(ra(0, 'h00), 64'h3);
        repeat (5) @(negedge clk);
        rd_chk("t5_status_run", ra(0, 'h20), 64'h201);
        d_seen = done_seen[0];
        do_reset();
        check("t5_start", 64'(ch_start), 64'h0);
        check("t5_addr0", ch_addr[0], 64'h0);
        check("t5_len0", 64'(ch_len[0]), 64'h0);
        check("t5_irq", 64'(irq), 64'h0);
        rd_chk("t5_status", ra(0, 'h20), 64'h2);
        repeat (40) @(negedge clk);
        check("t5_engine_pulsed", 64'(done_seen[0] - d_seen), 64'd1);
        rd_chk("t5_done_cnt", ra(0, 'h30), 64'd0);
        rd_chk("t5_events", ra(0, 'h28), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dma_csr_queue.md
DMA_CSR_QUEUE -- requirements
Module: dma_csr_queue

Interface
REQ-001 SHALL have parameter N_CH, default 2, number of DMA channels (1..8).
REQ-002 SHALL have parameter DESC_DEPTH, default 4, descriptors per channel FIFO (power of 2, 2..16).
REQ-003 SHALL have parameter MMIO_BASE, default 64'h4000_0000, base of a 4 KB window.
REQ-004 SHALL have parameter LEN_W, default 32, packet-count width.
REQ-005 SHALL have port clk  in  1  the single clock; all logic is on the rising edge.
REQ-006 SHALL have port rstn  in  1  reset, synchronous, active-low.
REQ-007 SHALL have ports addr  in  64, wdata  in  64, we  in  1, rdata  out  64: CPU DMEM-style access.
REQ-008 SHALL have ports ch_start  out  N_CH, ch_addr  out  N_CH x 64, ch_len  out  N_CH x LEN_W: one descriptor per channel, presented to the engine.
REQ-009 SHALL have ports ch_busy  in  N_CH, ch_done  in  N_CH (1-cycle pulse), ch_err  in  N_CH (1-cycle pulse): engine status.
REQ-010 SHALL have port irq  out  1: level interrupt.

Function
REQ-011 SHALL decode accesses where (addr & ~64'hFFF) == MMIO_BASE; other accesses SHALL be ignored, and rdata SHALL read 0 for them.
REQ-012 SHALL use per-channel register block at offset ch*0x40; global IRQ_STATUS at 0xF00 (RO, bit c = channel c irq contribution).
REQ-013 SHALL implement per-channel registers:
  - 0x00 CTRL [0]=enable, [1]=irq_en, [2]=flush (self-clearing, reads 0).
  - 0x08 ADDR staging (64b).
  - 0x10 LEN staging (LEN_W).
  - 0x18 PUSH: any write enqueues {ADDR, LEN}.
  - 0x20 STATUS RO: [0]=busy, [1]=empty, [2]=full, [15:8]=fifo count.
  - 0x28 EVENTS W1C: [0]=done, [1]=overflow, [2]=err.
  - 0x30 DONE_CNT RO, 32b, wraps at 2^32.
REQ-014 SHALL return rdata combinationally from addr (zero read latency); undefined offsets SHALL read 0.
REQ-015 SHALL, on a PUSH write while the FIFO is full and no pop occurs in that cycle, drop the descriptor and set EVENTS.overflow.
REQ-016 SHALL, on a simultaneous push and pop while the FIFO is full, accept the push (count unchanged, no overflow).
REQ-017 SHALL run a per-channel FSM with states IDLE, ISSUE, RUN.
REQ-018 IDLE->ISSUE SHALL occur when enable=1, the FIFO is non-empty and head LEN != 0; the head is popped into ch_addr/ch_len at that edge.
REQ-019 SHALL, when the head LEN == 0, pop it in IDLE without asserting ch_start, set EVENTS.done and increment DONE_CNT in the same cycle.
REQ-020 In ISSUE, SHALL hold ch_start=1 and ch_addr/ch_len stable until ch_busy=1, then go to RUN with ch_start=0 at the next edge.
REQ-021 In RUN, ch_done SHALL set EVENTS.done, increment DONE_CNT and return the FSM to IDLE; ch_err SHALL set EVENTS.err and return to IDLE without incrementing DONE_CNT.
REQ-022 SHALL take at least 1 cycle between RUN->IDLE and the next ISSUE (back-to-back start gap of 1 idle cycle).
REQ-023 SHALL report STATUS.busy = (state != IDLE).
REQ-024 Clearing enable SHALL stop new issues only; an in-flight descriptor SHALL complete.
REQ-025 flush SHALL empty the FIFO the next cycle without affecting an in-flight descriptor; a PUSH in the same cycle as flush SHALL be discarded.
REQ-026 W1C of an event bit in the same cycle it is set SHALL leave the bit set (set wins).
REQ-027 SHALL drive irq = OR over channels of (irq_en & |EVENTS), registered (1-cycle latency from the event).

Reset
REQ-028 While rstn=0 at a clock edge, SHALL clear all CTRL, staging, EVENTS and DONE_CNT to 0, empty the FIFOs, and put FSMs in IDLE.
REQ-029 SHALL drive ch_start=0, ch_addr=0, ch_len=0, irq=0 after reset, including when reset is asserted mid-ISSUE/RUN; engine pulses during reset SHALL be ignored.

Structure
REQ-030 The shared package SHALL hold the register offsets, the channel stride (0x40), the status/event bit positions and the descriptor struct typedef {addr, len}.
REQ-031 SHALL use one sub-module, desc_fifo (parametrised width/depth, sync FIFO with count), instantiated per channel via generate.

Verification
REQ-032 Ch0: ADDR=0x1000, LEN=3, PUSH, enable; engine busy after 2 cycles, done 10 cycles later -> ch_start high exactly until busy, ch_addr=0x1000, ch_len=3, DONE_CNT=1, EVENTS=0x1.
REQ-033 DESC_DEPTH=4, enable=0: 5 PUSHes -> STATUS.full=1, count=4, EVENTS.overflow=1; enable -> exactly 4 starts issued.
REQ-034 PUSH LEN=0 with irq_en=1 -> no ch_start, DONE_CNT=1, irq=1 one cycle later; W1C 0x1 -> irq=0.
REQ-035 Ch0 and ch1 active concurrently with ch1 ch_err -> ch1 EVENTS.err=1, DONE_CNT1=0; ch0 unaffected; IRQ_STATUS=0x2 when only ch1 irq_en=1.
REQ-036 rstn=0 during RUN with 2 queued -> all outputs 0, count=0; post-reset ch_done pulse -> no DONE_CNT change.
